// File: rtl/spatz_vrf_bank_arbiter_pkg.sv
// Shared types and constants for the VRF read-port bank arbiter.
// Optional feature macro: SPATZ_VRF_PRIO_EN (high-priority read requests).
package spatz_vrf_bank_arbiter_pkg;

  localparam int unsigned NrVRFBanks     = 4;
  localparam int unsigned VRFWordWidth   = 32;
  localparam int unsigned NrVreg         = 32;
  localparam int unsigned NrWordsPerBank = 8;
  localparam int unsigned NrRdPortsDef   = 6;

  localparam int unsigned VregRowW = $clog2(NrVreg * NrWordsPerBank);
  localparam int unsigned VrfBankW = $clog2(NrVRFBanks);

  // Read address as seen by a requesting port: row inside a bank, plus the bank select.
  typedef struct packed {
    logic [VregRowW-1:0] vreg;
    logic [VrfBankW-1:0] bank;
  } vreg_addr_t;

  typedef enum logic [2:0] {
    VfuRd0, VfuRd1, VfuRd2, VlsuRd0, VlsuRd1, VsldRd
  } vreg_port_rd_e;

  typedef logic [$clog2(NrRdPortsDef)-1:0] vrf_port_idx_t;

  // Index width that stays legal for a count of one.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spatz_vrf_bank_arbiter_rr.sv
// Per-bank round-robin arbiter: request vector (+ optional priority) to one-hot grant,
// winner index and the bank's rotating pointer. Macro: SPATZ_VRF_PRIO_EN.
module spatz_vrf_bank_arbiter_rr
  import spatz_vrf_bank_arbiter_pkg::*;
#(
  parameter int unsigned NrPorts = 6,
  localparam int unsigned IdxW   = idx_w(NrPorts)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NrPorts-1:0] req_i,
`ifdef SPATZ_VRF_PRIO_EN
  input  logic [NrPorts-1:0] prio_i,
`endif
  output logic [NrPorts-1:0] gnt_o,
  output logic [IdxW-1:0]    idx_o,
  output logic               valid_o
);

  logic [IdxW-1:0]    ptr_q, ptr_d;
  logic [NrPorts-1:0] cand;

  // Pick the first candidate at or after the pointer, wrapping around; advance past it.
  always_comb begin : p_pick
    int unsigned     p;
    logic [IdxW-1:0] pi;
    p       = 0;
    pi      = '0;
    cand    = req_i;
`ifdef SPATZ_VRF_PRIO_EN
    // High-priority requesters shadow the rest; RR still rotates within that class.
    if (|(req_i & prio_i)) cand = req_i & prio_i;
`endif
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned k = 0; k < NrPorts; k++) begin
      p = 32'(ptr_q) + k;
      if (p >= NrPorts) p = p - NrPorts;
      pi = p[IdxW-1:0];
      if (!valid_o && cand[pi]) begin
        valid_o   = 1'b1;
        idx_o     = pi;
        gnt_o[pi] = 1'b1;
      end
    end
    ptr_d = ptr_q;
    if (valid_o) ptr_d = (idx_o == IdxW'(NrPorts - 1)) ? '0 : idx_o + 1'b1;
  end

  // Rotating pointer state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/spatz_vrf_bank_arbiter.sv
// VRF read-port arbiter: decodes port addresses into bank/row, arbitrates each bank with
// its own round-robin, and returns bank data to the granted port through a fixed-latency
// tag pipeline. Macro: SPATZ_VRF_PRIO_EN adds rd_prio_i and priority classes.
module spatz_vrf_bank_arbiter
  import spatz_vrf_bank_arbiter_pkg::*;
#(
  parameter int unsigned NrRdPorts   = 6,
  parameter int unsigned NrBanks     = NrVRFBanks,
  parameter int unsigned VregAddrW   = VregRowW,
  parameter int unsigned DataWidth   = VRFWordWidth,
  parameter int unsigned ReadLatency = 1,
  localparam int unsigned BankW      = idx_w(NrBanks),
  localparam int unsigned AddrW      = VregAddrW + BankW,
  localparam int unsigned IdxW       = idx_w(NrRdPorts)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NrRdPorts-1:0]           rd_req_i,
  input  logic [NrRdPorts*AddrW-1:0]     rd_addr_i,
`ifdef SPATZ_VRF_PRIO_EN
  input  logic [NrRdPorts-1:0]           rd_prio_i,
`endif
  output logic [NrRdPorts-1:0]           rd_gnt_o,
  output logic [NrRdPorts-1:0]           rd_rvalid_o,
  output logic [NrRdPorts*DataWidth-1:0] rd_rdata_o,
  output logic [NrBanks-1:0]             bank_req_o,
  output logic [NrBanks*VregAddrW-1:0]   bank_addr_o,
  input  logic [NrBanks*DataWidth-1:0]   bank_rdata_i
);

  if (ReadLatency == 0) begin : gen_lat_chk
    $error("ReadLatency must be at least 1");
  end

  logic [NrRdPorts-1:0]                  req_eff;
  logic [NrRdPorts-1:0][VregAddrW-1:0]   port_row;
  logic [NrRdPorts-1:0][BankW-1:0]       port_bank;
  logic [NrBanks-1:0][NrRdPorts-1:0]     bank_mask;
  logic [NrBanks-1:0][NrRdPorts-1:0]     bank_gnt;
  logic [NrBanks-1:0][IdxW-1:0]          bank_idx;
  logic [NrBanks-1:0]                    bank_vld;
  logic [NrRdPorts-1:0][DataWidth-1:0]   rdata_mux;

  logic [NrBanks-1:0][ReadLatency-1:0]           tag_vld_q, tag_vld_d;
  logic [NrBanks-1:0][ReadLatency-1:0][IdxW-1:0] tag_idx_q, tag_idx_d;

  // Requests are masked during reset so grants and bank enables stay low.
  assign req_eff = rd_req_i & {NrRdPorts{rst_ni}};

  // Split each port address into row and bank, and build per-bank request masks.
  always_comb begin
    bank_mask = '0;
    for (int unsigned p = 0; p < NrRdPorts; p++) begin
      {port_row[p], port_bank[p]} = rd_addr_i[p*AddrW +: AddrW];
      for (int unsigned b = 0; b < NrBanks; b++) begin
        if ((NrBanks == 1) || (port_bank[p] == BankW'(b))) bank_mask[b][p] = req_eff[p];
      end
    end
  end

  for (genvar b = 0; b < NrBanks; b++) begin : gen_bank
    spatz_vrf_bank_arbiter_rr #(
      .NrPorts (NrRdPorts)
    ) u_rr (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .req_i   (bank_mask[b]),
`ifdef SPATZ_VRF_PRIO_EN
      .prio_i  (rd_prio_i),
`endif
      .gnt_o   (bank_gnt[b]),
      .idx_o   (bank_idx[b]),
      .valid_o (bank_vld[b])
    );

    assign bank_req_o[b]                          = bank_vld[b];
    assign bank_addr_o[b*VregAddrW +: VregAddrW]  = port_row[bank_idx[b]];
  end

  // A port targets one bank at a time, so OR-ing the bank grants gives at most one per port.
  always_comb begin
    rd_gnt_o = '0;
    for (int unsigned b = 0; b < NrBanks; b++) rd_gnt_o = rd_gnt_o | bank_gnt[b];
  end

  // Tag pipeline next state: stage 0 captures this cycle's winner, later stages shift.
  always_comb begin
    for (int unsigned b = 0; b < NrBanks; b++) begin
      tag_vld_d[b][0] = bank_vld[b];
      tag_idx_d[b][0] = bank_idx[b];
      for (int unsigned s = 1; s < ReadLatency; s++) begin
        tag_vld_d[b][s] = tag_vld_q[b][s-1];
        tag_idx_d[b][s] = tag_idx_q[b][s-1];
      end
    end
  end

  // Tag pipeline state; reset drops every in-flight read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_vld_q <= '0;
      tag_idx_q <= '0;
    end else begin
      tag_vld_q <= tag_vld_d;
      tag_idx_q <= tag_idx_d;
    end
  end

  // Route each retiring bank's data to the port recorded in its last tag stage.
  always_comb begin
    rd_rvalid_o = '0;
    rdata_mux   = '0;
    for (int unsigned b = 0; b < NrBanks; b++) begin
      if (tag_vld_q[b][ReadLatency-1]) begin
        rd_rvalid_o[tag_idx_q[b][ReadLatency-1]] = 1'b1;
        rdata_mux[tag_idx_q[b][ReadLatency-1]]   = bank_rdata_i[b*DataWidth +: DataWidth];
      end
    end
  end

  assign rd_rdata_o = rdata_mux;

  for (genvar p = 0; p < NrRdPorts; p++) begin : gen_hold_chk
    // A waiting requester must keep its request and address until it is granted.
    a_req_hold : assert property (@(posedge clk_i) disable iff (!rst_ni)
      rd_req_i[p] && !rd_gnt_o[p] |=> rd_req_i[p] && $stable(rd_addr_i[p*AddrW +: AddrW]));
  end

endmodule

// File: tb/tb_spatz_vrf_bank_arbiter.sv
// Randomised scoreboard bench for spatz_vrf_bank_arbiter (3-cycle bank latency).
module tb_spatz_vrf_bank_arbiter;
  localparam int NP = 6, NB = 4, RW = 8, BW = 2, AW = RW + BW, DW = 32, L = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0]    rd_req, rd_gnt, rd_rvalid;
  logic [NP*AW-1:0] rd_addr;
  logic [NP*DW-1:0] rd_rdata;
  logic [NB-1:0]    bank_req;
  logic [NB*RW-1:0] bank_addr;
  logic [NB*DW-1:0] bank_rdata;
`ifdef SPATZ_VRF_PRIO_EN
  logic [NP-1:0]    rd_prio;
`endif

  spatz_vrf_bank_arbiter #(
    .NrRdPorts   (NP),
    .NrBanks     (NB),
    .VregAddrW   (RW),
    .DataWidth   (DW),
    .ReadLatency (L)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rd_req_i     (rd_req),
    .rd_addr_i    (rd_addr),
`ifdef SPATZ_VRF_PRIO_EN
    .rd_prio_i    (rd_prio),
`endif
    .rd_gnt_o     (rd_gnt),
    .rd_rvalid_o  (rd_rvalid),
    .rd_rdata_o   (rd_rdata),
    .bank_req_o   (bank_req),
    .bank_addr_o  (bank_addr),
    .bank_rdata_i (bank_rdata)
  );

  typedef struct { int due; logic [DW-1:0] data; } rsp_t;
  typedef struct { logic [NP-1:0] gnt; logic [NB-1:0] breq; logic [NB*RW-1:0] baddr; } cyc_t;

  int   nvec = 0, nerr = 0;
  int   cyc = 0;
  bit   act[NP];
  int   abank[NP], arow[NP];
  bit   aprio[NP];
  int   ptr[NB];
  rsp_t exp_rsp[NP][$];
  cyc_t exp_cyc[$];
  logic [NB-1:0] hist_req[0:4095];
  int   hist_row[0:4095][NB];

  // Contents of the modelled SRAM.
  function automatic logic [DW-1:0] memw(input int b, input int row);
    return 32'hC0DE_0000 ^ (32'(b) << 28) ^ (32'(row) * 32'h0001_0003);
  endfunction

  // mode 0: random traffic, 1: every idle port hammers bank 0, 2: no new requests,
  // 3: ports 0..3 to banks 0..3 rows 5..8
  task automatic drive_cycle(input bit in_rst, input int mode);
    cyc_t e;
    bit   cand[NP];
    bit   gnt_now[NP];
    bit   anyp;
    int   w, p;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = !in_rst;
    if (in_rst) begin
      for (int i = 0; i < NP; i++) begin
        exp_rsp[i].delete();
        act[i] = 1'b0;
      end
      for (int b = 0; b < NB; b++) ptr[b] = 0;
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (!act[i]) begin
          case (mode)
            0: if ($urandom_range(1) == 1) begin
                 act[i] = 1'b1; abank[i] = $urandom_range(NB - 1);
                 arow[i] = $urandom_range(255); aprio[i] = ($urandom_range(3) == 0);
               end
            1: begin act[i] = 1'b1; abank[i] = 0; arow[i] = $urandom_range(255);
                     aprio[i] = ($urandom_range(3) == 0); end
            3: if (i < 4) begin act[i] = 1'b1; abank[i] = i; arow[i] = 5 + i; aprio[i] = 1'b0; end
            default: ;
          endcase
        end
      end
    end
    for (int i = 0; i < NP; i++) begin
      rd_req[i] = act[i];
      rd_addr[i*AW +: AW] = {RW'(arow[i]), BW'(abank[i])};
`ifdef SPATZ_VRF_PRIO_EN
      rd_prio[i] = aprio[i];
`endif
    end
    for (int b = 0; b < NB; b++) begin
      if (cyc >= L && hist_req[cyc-L][b]) bank_rdata[b*DW +: DW] = memw(b, hist_row[cyc-L][b]);
      else bank_rdata[b*DW +: DW] = $urandom;
    end
    // Reference: per bank, first eligible requester from the pointer, wrapping
    e.gnt = '0; e.breq = '0; e.baddr = '0;
    for (int i = 0; i < NP; i++) gnt_now[i] = 1'b0;
    for (int b = 0; b < NB; b++) begin
      hist_req[cyc][b] = 1'b0;
      for (int i = 0; i < NP; i++) cand[i] = !in_rst && act[i] && abank[i] == b;
`ifdef SPATZ_VRF_PRIO_EN
      anyp = 1'b0;
      for (int i = 0; i < NP; i++) if (cand[i] && aprio[i]) anyp = 1'b1;
      if (anyp) for (int i = 0; i < NP; i++) cand[i] = cand[i] && aprio[i];
`else
      anyp = 1'b0;
`endif
      w = -1;
      for (int k = 0; k < NP; k++) begin
        p = (ptr[b] + k) % NP;
        if (w < 0 && cand[p]) w = p;
      end
      if (w >= 0) begin
        e.gnt[w] = 1'b1;
        e.breq[b] = 1'b1;
        e.baddr[b*RW +: RW] = RW'(arow[w]);
        hist_req[cyc][b] = 1'b1;
        hist_row[cyc][b] = arow[w];
        exp_rsp[w].push_back('{due: cyc + L, data: memw(b, arow[w])});
        gnt_now[w] = 1'b1;
        ptr[b] = (w + 1) % NP;
      end
    end
    for (int i = 0; i < NP; i++) if (gnt_now[i]) act[i] = 1'b0;
    exp_cyc.push_back(e);
  endtask

  // Monitor: compares the DUT against the expectations queued by the driver.
  initial begin
    cyc_t e;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (exp_cyc.size() > 0) begin
        e = exp_cyc.pop_front();
        nvec++;
        if (rd_gnt !== e.gnt) begin
          nerr++; $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, rd_gnt, e.gnt);
        end
        nvec++;
        if (bank_req !== e.breq) begin
          nerr++; $display("FAIL bank_req cyc=%0d got=%b exp=%b", cyc, bank_req, e.breq);
        end
        for (int b = 0; b < NB; b++) begin
          if (e.breq[b]) begin
            nvec++;
            if (bank_addr[b*RW +: RW] !== e.baddr[b*RW +: RW]) begin
              nerr++; $display("FAIL bank_addr cyc=%0d bank=%0d got=%0d exp=%0d", cyc, b,
                               bank_addr[b*RW +: RW], e.baddr[b*RW +: RW]);
            end
          end
        end
        for (int i = 0; i < NP; i++) begin
          nvec++;
          if (rd_rvalid[i] === 1'b1) begin
            if (exp_rsp[i].size() == 0) begin
              nerr++; $display("FAIL rvalid_unexpected cyc=%0d port=%0d got=1 exp=0", cyc, i);
            end else begin
              r = exp_rsp[i].pop_front();
              if (r.due != cyc) begin
                nerr++; $display("FAIL rvalid_time port=%0d got_cyc=%0d exp_cyc=%0d", i, cyc, r.due);
              end
              nvec++;
              if (rd_rdata[i*DW +: DW] !== r.data) begin
                nerr++; $display("FAIL rdata cyc=%0d port=%0d got=%h exp=%h", cyc, i,
                                 rd_rdata[i*DW +: DW], r.data);
              end
            end
          end else if (exp_rsp[i].size() > 0 && exp_rsp[i][0].due <= cyc) begin
            r = exp_rsp[i].pop_front();
            nerr++; $display("FAIL rvalid_missing cyc=%0d port=%0d got=%b exp=1", cyc, i, rd_rvalid[i]);
          end else if (rd_rvalid[i] !== 1'b0 || rd_rdata[i*DW +: DW] !== '0) begin
            nerr++; $display("FAIL idle_port cyc=%0d port=%0d got_v=%b got_d=%h exp=0", cyc, i,
                             rd_rvalid[i], rd_rdata[i*DW +: DW]);
          end
        end
      end
    end
  end

  initial begin
    rd_req = '0; rd_addr = '0; bank_rdata = '0;
`ifdef SPATZ_VRF_PRIO_EN
    rd_prio = '0;
`endif
    for (int i = 0; i < NP; i++) begin act[i] = 0; abank[i] = 0; arow[i] = 0; aprio[i] = 0; end
    for (int b = 0; b < NB; b++) ptr[b] = 0;
    for (int c = 0; c < 4096; c++) hist_req[c] = '0;
    repeat (3) drive_cycle(1'b1, 2);
    repeat (14) drive_cycle(1'b0, 1);   // contention on one bank, pointer wrap
    repeat (10) drive_cycle(1'b0, 2);   // drain
    drive_cycle(1'b0, 3);                // four banks in parallel
    repeat (6) drive_cycle(1'b0, 2);
    repeat (700) drive_cycle(1'b0, 0);
    drive_cycle(1'b1, 2);                // reset with reads in flight
    repeat (2) drive_cycle(1'b0, 1);
    repeat (700) drive_cycle(1'b0, 0);
    repeat (20) drive_cycle(1'b0, 2);
    @(negedge clk);
    #1;
    for (int i = 0; i < NP; i++) begin
      nvec++;
      if (exp_rsp[i].size() != 0) begin
        nerr++; $display("FAIL drain port=%0d got_pending=%0d exp=0", i, exp_rsp[i].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
